// File: rtl/hack_pkg.sv
// Shared definitions for the handshaked Hack CPU core: FSM states,
// C-instruction field positions, dest/jump encodings and named ALU codes.
package hack_pkg;

    // Instruction sequencing states
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // C-instruction field positions (always within the low 16 bits)
    localparam int A_BIT   = 12;
    localparam int COMP_HI = 11;
    localparam int COMP_LO = 6;
    localparam int DEST_HI = 5;
    localparam int DEST_LO = 3;
    localparam int JUMP_HI = 2;
    localparam int JUMP_LO = 0;

    // Bit indices inside the 3-bit dest field
    localparam int DEST_A = 2;
    localparam int DEST_D = 1;
    localparam int DEST_M = 0;

    // Bit indices inside the 3-bit jump field
    localparam int J_LT = 2;
    localparam int J_EQ = 1;
    localparam int J_GT = 0;

    // dest encodings
    localparam logic [2:0] DST_NONE = 3'b000;
    localparam logic [2:0] DST_M    = 3'b001;
    localparam logic [2:0] DST_D    = 3'b010;
    localparam logic [2:0] DST_MD   = 3'b011;
    localparam logic [2:0] DST_A    = 3'b100;
    localparam logic [2:0] DST_AM   = 3'b101;
    localparam logic [2:0] DST_AD   = 3'b110;
    localparam logic [2:0] DST_AMD  = 3'b111;

    // jump encodings
    localparam logic [2:0] JNULL = 3'b000;
    localparam logic [2:0] JGT   = 3'b001;
    localparam logic [2:0] JEQ   = 3'b010;
    localparam logic [2:0] JGE   = 3'b011;
    localparam logic [2:0] JLT   = 3'b100;
    localparam logic [2:0] JNE   = 3'b101;
    localparam logic [2:0] JLE   = 3'b110;
    localparam logic [2:0] JMP   = 3'b111;

    // comp codes {zx,nx,zy,ny,f,no}; "A" reads as "M" when a=1
    localparam logic [5:0] COMP_ZERO  = 6'b101010;
    localparam logic [5:0] COMP_ONE   = 6'b111111;
    localparam logic [5:0] COMP_NEG1  = 6'b111010;
    localparam logic [5:0] COMP_D     = 6'b001100;
    localparam logic [5:0] COMP_A     = 6'b110000;
    localparam logic [5:0] COMP_NOT_D = 6'b001101;
    localparam logic [5:0] COMP_NOT_A = 6'b110001;
    localparam logic [5:0] COMP_NEG_D = 6'b001111;
    localparam logic [5:0] COMP_NEG_A = 6'b110011;
    localparam logic [5:0] COMP_D_P1  = 6'b011111;
    localparam logic [5:0] COMP_A_P1  = 6'b110111;
    localparam logic [5:0] COMP_D_M1  = 6'b001110;
    localparam logic [5:0] COMP_A_M1  = 6'b110010;
    localparam logic [5:0] COMP_D_PA  = 6'b000010;
    localparam logic [5:0] COMP_D_MA  = 6'b010011;
    localparam logic [5:0] COMP_A_MD  = 6'b000111;
    localparam logic [5:0] COMP_D_AND = 6'b000000;
    localparam logic [5:0] COMP_D_OR  = 6'b010101;

    // Build a 16-bit C-instruction word
    function automatic logic [15:0] mk_c(input logic a, input logic [5:0] comp,
                                         input logic [2:0] dest, input logic [2:0] jump);
        return {3'b111, a, comp, dest, jump};
    endfunction

endpackage

// File: rtl/hack_alu.sv
// Combinational Hack ALU over WIDTH bits with zero/negative flags.
module hack_alu #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [5:0]       comp_i,
    output logic [WIDTH-1:0] y_o,
    output logic             zr_o,
    output logic             ng_o
);

    logic [WIDTH-1:0] xs_s;
    logic [WIDTH-1:0] ys_s;
    logic [WIDTH-1:0] fo_s;

    // zx/nx/zy/ny preconditioning, f select, no postcondition, flags
    always_comb begin
        xs_s = x_i;
        ys_s = y_i;
        fo_s = {WIDTH{1'b0}};
        if (comp_i[5]) begin
            xs_s = {WIDTH{1'b0}};
        end else begin
            xs_s = x_i;
        end
        if (comp_i[4]) begin
            xs_s = ~xs_s;
        end else begin
            xs_s = xs_s;
        end
        if (comp_i[3]) begin
            ys_s = {WIDTH{1'b0}};
        end else begin
            ys_s = y_i;
        end
        if (comp_i[2]) begin
            ys_s = ~ys_s;
        end else begin
            ys_s = ys_s;
        end
        if (comp_i[1]) begin
            fo_s = xs_s + ys_s;
        end else begin
            fo_s = xs_s & ys_s;
        end
        if (comp_i[0]) begin
            y_o = ~fo_s;
        end else begin
            y_o = fo_s;
        end
        zr_o = (y_o == {WIDTH{1'b0}});
        ng_o = y_o[WIDTH-1];
    end

endmodule

// File: rtl/hack_cpu_hs.sv
// Multi-cycle Hack CPU core with valid/ack handshakes on instruction fetch
// and data memory. One instruction walks FETCH -> [READ] -> [WRITE] -> COMMIT.
module hack_cpu_hs
    import hack_pkg::*;
#(
    parameter int                WIDTH        = 16,
    parameter int                ADDR_W       = WIDTH - 1,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] pc,
    input  logic [WIDTH-1:0]  instr_data,
    input  logic              instr_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ack,
    output logic              retire,
    output logic [WIDTH-1:0]  d_out,
    output logic [WIDTH-1:0]  a_out
);

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] pc_q,        pc_d;
    logic [WIDTH-1:0]  a_q,         a_d;
    logic [WIDTH-1:0]  d_q,         d_d;
    logic [WIDTH-1:0]  ir_q,        ir_d;
    logic [WIDTH-1:0]  mr_q,        mr_d;
    logic              mem_re_q,    mem_re_d;
    logic              mem_we_q,    mem_we_d;
    logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic              retire_q,    retire_d;

    // Decode always looks at the instruction being worked on: the incoming
    // word while it is fetched, the latched IR afterwards. Likewise the M
    // operand comes straight from mem_rdata in the cycle MR is captured, so
    // the write data registered on entry to WRITE is already correct.
    logic [WIDTH-1:0]  cur_ir_s;
    logic              is_c_s;
    logic              a_sel_s;
    logic [2:0]        dest_s;
    logic [2:0]        jump_s;
    logic [WIDTH-1:0]  m_opnd_s;
    logic [WIDTH-1:0]  alu_y_s;
    logic              alu_zr_s;
    logic              alu_ng_s;
    logic              taken_s;
    logic              unused_s;

    assign cur_ir_s = (state_q == FETCH) ? instr_data : ir_q;
    assign is_c_s   = cur_ir_s[WIDTH-1];
    assign a_sel_s  = cur_ir_s[A_BIT];
    assign dest_s   = cur_ir_s[DEST_HI:DEST_LO];
    assign jump_s   = cur_ir_s[JUMP_HI:JUMP_LO];
    assign m_opnd_s = (state_q == READ) ? mem_rdata : mr_q;
    assign unused_s = ^cur_ir_s[WIDTH-2:13];

    hack_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .x_i    (d_q),
        .y_i    (a_sel_s ? m_opnd_s : a_q),
        .comp_i (cur_ir_s[COMP_HI:COMP_LO]),
        .y_o    (alu_y_s),
        .zr_o   (alu_zr_s),
        .ng_o   (alu_ng_s)
    );

    assign taken_s = (jump_s[J_LT] & alu_ng_s) |
                     (jump_s[J_EQ] & alu_zr_s) |
                     (jump_s[J_GT] & ~alu_ng_s & ~alu_zr_s);

    // Next-state and datapath update for each instruction phase
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        a_d         = a_q;
        d_d         = d_q;
        ir_d        = ir_q;
        mr_d        = mr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            FETCH: begin
                if (instr_valid) begin
                    ir_d = instr_data;
                    if (is_c_s && a_sel_s) begin
                        state_d = READ;
                    end else if (is_c_s && dest_s[DEST_M]) begin
                        state_d     = WRITE;
                        mem_wdata_d = alu_y_s;
                    end else begin
                        state_d = COMMIT;
                    end
                end else begin
                    state_d = FETCH;
                end
            end
            READ: begin
                if (mem_ack) begin
                    mr_d = mem_rdata;
                    if (dest_s[DEST_M]) begin
                        state_d     = WRITE;
                        mem_wdata_d = alu_y_s;
                    end else begin
                        state_d = COMMIT;
                    end
                end else begin
                    state_d = READ;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    state_d = COMMIT;
                end else begin
                    state_d = WRITE;
                end
            end
            COMMIT: begin
                state_d = FETCH;
                if (!is_c_s) begin
                    a_d  = {{(WIDTH-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
                    pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end else begin
                    if (dest_s[DEST_A]) begin
                        a_d = alu_y_s;
                    end else begin
                        a_d = a_q;
                    end
                    if (dest_s[DEST_D]) begin
                        d_d = alu_y_s;
                    end else begin
                        d_d = d_q;
                    end
                    // jump target is the A value from before this commit
                    if (taken_s) begin
                        pc_d = a_q[ADDR_W-1:0];
                    end else begin
                        pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        mem_re_d = (state_d == READ);
        mem_we_d = (state_d == WRITE);
        retire_d = (state_d == COMMIT);
    end

    // State and output registers; reset abandons any pending request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_VECTOR;
            a_q         <= {WIDTH{1'b0}};
            d_q         <= {WIDTH{1'b0}};
            ir_q        <= {WIDTH{1'b0}};
            mr_q        <= {WIDTH{1'b0}};
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= {WIDTH{1'b0}};
            retire_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            a_q         <= a_d;
            d_q         <= d_d;
            ir_q        <= ir_d;
            mr_q        <= mr_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            retire_q    <= retire_d;
        end
    end

    assign pc        = pc_q;
    assign mem_addr  = a_q[ADDR_W-1:0];
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign retire    = retire_q;
    assign d_out     = d_q;
    assign a_out     = a_q;

endmodule

// File: tb/tb_hack_cpu_hs.sv
// Directed bench for hack_cpu_hs: a 16-bit core with a handshaking memory
// model and a 24-bit core driven with fixed zero-wait fetches.
module tb_hack_cpu_hs;
    import hack_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] pc;
    logic [15:0] instr_data;
    logic        instr_valid;
    logic [14:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        retire;
    logic [15:0] d_out;
    logic [15:0] a_out;

    logic [22:0] pc_w;
    logic [23:0] instr_data_w;
    logic        instr_valid_w;
    logic [22:0] mem_addr_w;
    logic        mem_re_w;
    logic        mem_we_w;
    logic [23:0] mem_wdata_w;
    logic [23:0] mem_rdata_w;
    logic        mem_ack_w;
    logic        retire_w;
    logic [23:0] d_out_w;
    logic [23:0] a_out_w;

    int          n_tests = 0;
    int          n_fail  = 0;

    int          lat;
    int          re_cyc;
    int          we_cyc;
    logic [14:0] re_adr;
    logic [14:0] we_adr;
    logic [15:0] we_dat;
    bit          we_stable;
    bit          pc_moved;
    bit          both_hi = 1'b0;

    hack_cpu_hs u_dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .instr_data  (instr_data),
        .instr_valid (instr_valid),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .retire      (retire),
        .d_out       (d_out),
        .a_out       (a_out)
    );

    hack_cpu_hs #(.WIDTH(24), .ADDR_W(23)) u_dut_w (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc_w),
        .instr_data  (instr_data_w),
        .instr_valid (instr_valid_w),
        .mem_addr    (mem_addr_w),
        .mem_re      (mem_re_w),
        .mem_we      (mem_we_w),
        .mem_wdata   (mem_wdata_w),
        .mem_rdata   (mem_rdata_w),
        .mem_ack     (mem_ack_w),
        .retire      (retire_w),
        .d_out       (d_out_w),
        .a_out       (a_out_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Run one instruction on the 16-bit core starting at a negedge in FETCH.
    // The memory model acks after ack_wait wait cycles in each phase.
    task automatic exec(input string tag, input logic [15:0] ins, input int ack_wait,
                        input logic [15:0] rdata, input int exp_pc, input int exp_lat);
        int hold;
        bit done;
        lat       = 1;
        re_cyc    = 0;
        we_cyc    = 0;
        we_stable = 1'b1;
        pc_moved  = 1'b0;
        hold      = 0;
        done      = 1'b0;
        chk({tag, "_pc0"}, 32'(pc), 32'(exp_pc));
        instr_data  = ins;
        instr_valid = 1'b1;
        mem_ack     = 1'b0;
        mem_rdata   = rdata;
        while (!done && lat < 40) begin
            @(negedge clk);
            instr_valid = 1'b0;
            mem_ack     = 1'b0;
            lat++;
            if (mem_re && mem_we) both_hi = 1'b1;
            if (retire) begin
                done = 1'b1;
            end else begin
                if (pc !== 15'(exp_pc)) pc_moved = 1'b1;
                if (mem_re) begin
                    re_cyc++;
                    re_adr = mem_addr;
                end
                if (mem_we) begin
                    if (we_cyc == 0) begin
                        we_adr = mem_addr;
                        we_dat = mem_wdata;
                    end else if (mem_addr !== we_adr || mem_wdata !== we_dat) begin
                        we_stable = 1'b0;
                    end
                    we_cyc++;
                end
                if (mem_re || mem_we) begin
                    if (hold == ack_wait) begin
                        mem_ack = 1'b1;
                        hold    = 0;
                    end else begin
                        hold++;
                    end
                end
            end
        end
        chk({tag, "_retired"}, 32'(done), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_pc_hold"}, 32'(pc_moved), 32'd0);
        mem_ack = 1'b0;
        @(negedge clk);
    endtask

    // Run one zero-wait, memory-free instruction on the 24-bit core
    task automatic exec_w(input string tag, input logic [23:0] ins);
        instr_data_w  = ins;
        instr_valid_w = 1'b1;
        @(negedge clk);
        instr_valid_w = 1'b0;
        chk({tag, "_retire"}, 32'(retire_w), 32'd1);
        chk({tag, "_nomem"}, 32'(mem_re_w | mem_we_w), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        instr_data    = 16'd0;
        instr_valid   = 1'b0;
        mem_rdata     = 16'd0;
        mem_ack       = 1'b0;
        instr_data_w  = 24'd0;
        instr_valid_w = 1'b0;
        mem_rdata_w   = 24'd0;
        mem_ack_w     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_a", 32'(a_out), 32'd0);
        chk("rst_d", 32'(d_out), 32'd0);
        chk("rst_re_we", 32'({mem_re, mem_we}), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        reset = 1'b0;

        // @12345 ; D=A
        exec("a12345", 16'd12345, 0, 16'd0, 0, 2);
        chk("a12345_mem", 32'(re_cyc + we_cyc), 32'd0);
        exec("d_eq_a", mk_c(1'b0, COMP_A, DST_D, JNULL), 0, 16'd0, 1, 2);
        chk("d_eq_a_mem", 32'(re_cyc + we_cyc), 32'd0);
        chk("d_eq_a_d", 32'(d_out), 32'd12345);
        chk("d_eq_a_a", 32'(a_out), 32'd12345);
        chk("d_eq_a_pc", 32'(pc), 32'd2);

        // D=11111, A=1000, M=D with three wait cycles
        exec("a11111", 16'd11111, 0, 16'd0, 2, 2);
        exec("d11111", mk_c(1'b0, COMP_A, DST_D, JNULL), 0, 16'd0, 3, 2);
        exec("a1000", 16'd1000, 0, 16'd0, 4, 2);
        exec("m_eq_d", mk_c(1'b0, COMP_D, DST_M, JNULL), 3, 16'd0, 5, 6);
        chk("m_eq_d_we_cyc", 32'(we_cyc), 32'd4);
        chk("m_eq_d_re_cyc", 32'(re_cyc), 32'd0);
        chk("m_eq_d_addr", 32'(we_adr), 32'd1000);
        chk("m_eq_d_data", 32'(we_dat), 32'd11111);
        chk("m_eq_d_stable", 32'(we_stable), 32'd1);
        chk("m_eq_d_pc", 32'(pc), 32'd6);

        // AM=M+1 at A=1000, M reads 5, two wait cycles per phase
        exec("am_inc", mk_c(1'b1, COMP_A_P1, DST_AM, JNULL), 2, 16'd5, 6, 8);
        chk("am_inc_re_cyc", 32'(re_cyc), 32'd3);
        chk("am_inc_re_addr", 32'(re_adr), 32'd1000);
        chk("am_inc_we_cyc", 32'(we_cyc), 32'd3);
        chk("am_inc_we_addr", 32'(we_adr), 32'd1000);
        chk("am_inc_we_data", 32'(we_dat), 32'd6);
        chk("am_inc_a", 32'(a_out), 32'd6);
        chk("am_inc_d", 32'(d_out), 32'd11111);
        chk("am_inc_pc", 32'(pc), 32'd7);

        // Jumps with A=14
        exec("a14_1", 16'd14, 0, 16'd0, 7, 2);
        exec("d_m1", mk_c(1'b0, COMP_NEG1, DST_D, JNULL), 0, 16'd0, 8, 2);
        chk("d_m1_d", 32'(d_out), 32'h0000_FFFF);
        exec("jlt", mk_c(1'b0, COMP_D, DST_NONE, JLT), 0, 16'd0, 9, 2);
        chk("jlt_pc", 32'(pc), 32'd14);
        exec("a14_2", 16'd14, 0, 16'd0, 14, 2);
        exec("d_0", mk_c(1'b0, COMP_ZERO, DST_D, JNULL), 0, 16'd0, 15, 2);
        exec("jgt_nt", mk_c(1'b0, COMP_D, DST_NONE, JGT), 0, 16'd0, 16, 2);
        chk("jgt_nt_pc", 32'(pc), 32'd17);
        exec("jeq", mk_c(1'b0, COMP_D, DST_NONE, JEQ), 0, 16'd0, 17, 2);
        chk("jeq_pc", 32'(pc), 32'd14);
        exec("d_1", mk_c(1'b0, COMP_ONE, DST_D, JNULL), 0, 16'd0, 14, 2);
        exec("jne", mk_c(1'b0, COMP_D, DST_NONE, JNE), 0, 16'd0, 15, 2);
        chk("jne_pc", 32'(pc), 32'd14);
        exec("jmp", mk_c(1'b0, COMP_ZERO, DST_NONE, JMP), 0, 16'd0, 14, 2);
        chk("jmp_pc", 32'(pc), 32'd14);

        // ALU patterns: D=1, A=14
        exec("d_sub", mk_c(1'b0, COMP_D_MA, DST_D, JNULL), 0, 16'd0, 14, 2);
        chk("d_sub_d", 32'(d_out), 32'h0000_FFF3);
        exec("a0f0f", 16'd3855, 0, 16'd0, 15, 2);
        exec("d_and", mk_c(1'b0, COMP_D_AND, DST_D, JNULL), 0, 16'd0, 16, 2);
        chk("d_and_d", 32'(d_out), 32'h0000_0F03);
        exec("d_not", mk_c(1'b0, COMP_NOT_D, DST_D, JNULL), 0, 16'd0, 17, 2);
        chk("d_not_d", 32'(d_out), 32'h0000_F0FC);
        exec("d_add", mk_c(1'b0, COMP_D_PA, DST_D, JNULL), 0, 16'd0, 18, 2);
        chk("d_add_wrap", 32'(d_out), 32'h0000_000B);
        exec("d_eq_m", mk_c(1'b1, COMP_A, DST_D, JNULL), 0, 16'h8001, 19, 3);
        chk("d_eq_m_re_cyc", 32'(re_cyc), 32'd1);
        chk("d_eq_m_we_cyc", 32'(we_cyc), 32'd0);
        chk("d_eq_m_addr", 32'(re_adr), 32'd3855);
        chk("d_eq_m_d", 32'(d_out), 32'h0000_8001);

        // Reset while WRITE waits for ack; a late ack must be ignored
        exec("a2000", 16'd2000, 0, 16'd0, 20, 2);
        instr_data  = mk_c(1'b0, COMP_D, DST_M, JNULL);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("mid_we", 32'(mem_we), 32'd1);
        chk("mid_addr", 32'(mem_addr), 32'd2000);
        chk("mid_data", 32'(mem_wdata), 32'h0000_8001);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_pc", 32'(pc), 32'd0);
        chk("mid_rst_d", 32'(d_out), 32'd0);
        chk("mid_rst_a", 32'(a_out), 32'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_re_we", 32'({mem_re, mem_we}), 32'd0);
        chk("late_ack_retire", 32'(retire), 32'd0);
        chk("late_ack_pc", 32'(pc), 32'd0);
        exec("post_rst", 16'd5, 0, 16'd0, 0, 2);
        chk("post_rst_a", 32'(a_out), 32'd5);

        // pc wrap at 32767
        exec("a32767", 16'd32767, 0, 16'd0, 1, 2);
        exec("jmp_top", mk_c(1'b0, COMP_ZERO, DST_NONE, JMP), 0, 16'd0, 2, 2);
        exec("wrap", 16'd5, 0, 16'd0, 32767, 2);
        chk("wrap_pc", 32'(pc), 32'd0);
        chk("wrap_a", 32'(a_out), 32'd5);
        chk("never_both", 32'(both_hi), 32'd0);

        // 24-bit core: wide immediate, ignored high C bits, wrap
        exec_w("w_a", 24'd8388607);
        chk("w_a_a", 32'(a_out_w), 32'd8388607);
        chk("w_a_pc", 32'(pc_w), 32'd1);
        exec_w("w_d", {8'hD5, mk_c(1'b0, COMP_A, DST_D, JNULL)});
        chk("w_d_d", 32'(d_out_w), 32'd8388607);
        exec_w("w_jmp", {8'h80, mk_c(1'b0, COMP_ZERO, DST_NONE, JMP)});
        chk("w_jmp_pc", 32'(pc_w), 32'd8388607);
        exec_w("w_wrap", 24'd3);
        chk("w_wrap_pc", 32'(pc_w), 32'd0);
        chk("w_wrap_a", 32'(a_out_w), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
